// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg
// Shared definitions for the LCD image controller: host command codes and
// the controller FSM state encoding.
package lcd_ctrl_pkg;

  localparam logic [3:0] CMD_WRITE    = 4'd0;
  localparam logic [3:0] CMD_UP       = 4'd1;
  localparam logic [3:0] CMD_DOWN     = 4'd2;
  localparam logic [3:0] CMD_LEFT     = 4'd3;
  localparam logic [3:0] CMD_RIGHT    = 4'd4;
  localparam logic [3:0] CMD_MAX      = 4'd5;
  localparam logic [3:0] CMD_MIN      = 4'd6;
  localparam logic [3:0] CMD_AVG      = 4'd7;
  localparam logic [3:0] CMD_CCW      = 4'd8;
  localparam logic [3:0] CMD_CW       = 4'd9;
  localparam logic [3:0] CMD_MIRX     = 4'd10;
  localparam logic [3:0] CMD_MIRY     = 4'd11;
  localparam logic [3:0] CMD_INVERT   = 4'd12;
  localparam logic [3:0] CMD_RECENTER = 4'd13;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_IDLE,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lcd_win_alu.sv
// lcd_win_alu
// Combinational 2x2 window operator. Given the four window pixels and the
// command code, produces the replacement pixels and a write-enable that is
// high only for commands that modify image data (MAX..INVERT).
// Ports:
//   tl, tr, bl, br        in   current window pixels
//   cmd                   in   command code
//   new_tl .. new_br      out  replacement pixels
//   we                    out  window must be written back
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] tl,
  input  logic [DATA_W-1:0] tr,
  input  logic [DATA_W-1:0] bl,
  input  logic [DATA_W-1:0] br,
  input  logic [3:0]        cmd,
  output logic [DATA_W-1:0] new_tl,
  output logic [DATA_W-1:0] new_tr,
  output logic [DATA_W-1:0] new_bl,
  output logic [DATA_W-1:0] new_br,
  output logic              we
);

  logic [DATA_W-1:0] max_top, max_bot, max_all;
  logic [DATA_W-1:0] min_top, min_bot, min_all;
  logic [DATA_W+1:0] sum;
  logic [DATA_W-1:0] avg;

  assign max_top = (tl > tr) ? tl : tr;
  assign max_bot = (bl > br) ? bl : br;
  assign max_all = (max_top > max_bot) ? max_top : max_bot;
  assign min_top = (tl < tr) ? tl : tr;
  assign min_bot = (bl < br) ? bl : br;
  assign min_all = (min_top < min_bot) ? min_top : min_bot;

  // Two guard bits make the four-way sum exact; floor division by 4 is a shift.
  assign sum = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
  assign avg = DATA_W'(sum >> 2);

  always_comb begin
    new_tl = tl;
    new_tr = tr;
    new_bl = bl;
    new_br = br;
    we     = 1'b0;
    case (cmd)
      CMD_MAX: begin
        new_tl = max_all; new_tr = max_all; new_bl = max_all; new_br = max_all;
        we = 1'b1;
      end
      CMD_MIN: begin
        new_tl = min_all; new_tr = min_all; new_bl = min_all; new_br = min_all;
        we = 1'b1;
      end
      CMD_AVG: begin
        new_tl = avg; new_tr = avg; new_bl = avg; new_br = avg;
        we = 1'b1;
      end
      CMD_CCW: begin
        new_tl = tr; new_tr = br; new_br = bl; new_bl = tl;
        we = 1'b1;
      end
      CMD_CW: begin
        new_tl = bl; new_bl = br; new_br = tr; new_tr = tl;
        we = 1'b1;
      end
      CMD_MIRX: begin
        new_tl = bl; new_bl = tl; new_tr = br; new_br = tr;
        we = 1'b1;
      end
      CMD_MIRY: begin
        new_tl = tr; new_tr = tl; new_bl = br; new_br = bl;
        we = 1'b1;
      end
      CMD_INVERT: begin
        new_tl = ~tl; new_tr = ~tr; new_bl = ~bl; new_br = ~br;
        we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param
// LCD image controller for an N x N image (N = 2**IMG_LOG2). Loads the image
// from IROM into a local pixel buffer, applies host commands to a 2x2 window
// anchored at the operation point (x,y), then streams the buffer to IRAM.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   cmd          in   command code, taken when cmd_valid && !busy
//   cmd_valid    in   command strobe
//   IROM_Q       in   ROM data, valid the cycle after IROM_rd/IROM_A
//   IROM_rd      out  ROM read enable
//   IROM_A       out  ROM address
//   IRAM_valid   out  RAM write enable
//   IRAM_D       out  RAM write data
//   IRAM_A       out  RAM write address
//   busy         out  no command can be accepted
//   done         out  write-out complete, held until reset
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | issue ROM reads 0..N*N-1, capture data one cycle later
// ST_IDLE  | busy low, waiting for a command
// ST_EXEC  | one-cycle window / point update
// ST_WRITE | stream buffer to IRAM, one pixel per cycle
// ST_DONE  | write-out finished, done held high
module lcd_ctrl_param
  import lcd_ctrl_pkg::*;
#(
  parameter int IMG_LOG2 = 3,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2 * IMG_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IROM_rd,
  output logic [ADDR_W-1:0] IROM_A,
  output logic              IRAM_valid,
  output logic [DATA_W-1:0] IRAM_D,
  output logic [ADDR_W-1:0] IRAM_A,
  output logic              busy,
  output logic              done
);

  localparam int N    = 1 << IMG_LOG2;
  localparam int NPIX = N * N;

  localparam logic [IMG_LOG2-1:0] PT_ONE = IMG_LOG2'(1);
  localparam logic [IMG_LOG2-1:0] PT_MID = IMG_LOG2'(N / 2);
  localparam logic [IMG_LOG2-1:0] PT_MAX = IMG_LOG2'(N - 1);
  localparam logic [ADDR_W-1:0]   A_LAST = ADDR_W'(NPIX - 1);

  state_t              state;
  logic [IMG_LOG2-1:0] pt_x, pt_y;
  logic [3:0]          cmd_r;
  logic                issue_done;
  logic                pend_valid;
  logic [ADDR_W-1:0]   pend_addr;
  logic [ADDR_W-1:0]   wr_idx;
  logic                wr_last;

  logic [DATA_W-1:0]   pix [NPIX];

  logic [IMG_LOG2-1:0] xm1, ym1;
  logic [ADDR_W-1:0]   a_tl, a_tr, a_bl, a_br;
  logic [DATA_W-1:0]   n_tl, n_tr, n_bl, n_br;
  logic                alu_we;
  logic                load_we;
  logic                exec_we;

  assign xm1  = pt_x - PT_ONE;
  assign ym1  = pt_y - PT_ONE;
  assign a_tl = {ym1, xm1};
  assign a_tr = {ym1, pt_x};
  assign a_bl = {pt_y, xm1};
  assign a_br = {pt_y, pt_x};

  lcd_win_alu #(.DATA_W(DATA_W)) u_alu (
    .tl     (pix[a_tl]),
    .tr     (pix[a_tr]),
    .bl     (pix[a_bl]),
    .br     (pix[a_br]),
    .cmd    (cmd_r),
    .new_tl (n_tl),
    .new_tr (n_tr),
    .new_bl (n_bl),
    .new_br (n_br),
    .we     (alu_we)
  );

  assign load_we = (state == ST_LOAD) && pend_valid;
  assign exec_we = (state == ST_EXEC) && alu_we;

  // Pixel storage carries no reset; its contents are reloaded after every reset.
  always_ff @(posedge clk) begin
    if (load_we) begin
      pix[pend_addr] <= IROM_Q;
    end
    if (exec_we) begin
      pix[a_tl] <= n_tl;
      pix[a_tr] <= n_tr;
      pix[a_bl] <= n_bl;
      pix[a_br] <= n_br;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      IROM_rd    <= 1'b0;
      IROM_A     <= '0;
      IRAM_valid <= 1'b0;
      IRAM_D     <= '0;
      IRAM_A     <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pt_x       <= PT_MID;
      pt_y       <= PT_MID;
      cmd_r      <= '0;
      issue_done <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      wr_idx     <= '0;
      wr_last    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          // Read issue runs one cycle ahead of capture; pend_* tracks the
          // address whose data IROM_Q is presenting this cycle.
          if (!issue_done) begin
            if (!IROM_rd) begin
              IROM_rd <= 1'b1;
            end else if (IROM_A == A_LAST) begin
              IROM_rd    <= 1'b0;
              issue_done <= 1'b1;
            end else begin
              IROM_A <= IROM_A + 1'b1;
            end
          end
          pend_valid <= IROM_rd;
          pend_addr  <= IROM_A;
          if (pend_valid && (pend_addr == A_LAST)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (cmd_valid && !busy) begin
            cmd_r   <= cmd;
            busy    <= 1'b1;
            wr_idx  <= '0;
            wr_last <= 1'b0;
            state   <= (cmd == CMD_WRITE) ? ST_WRITE : ST_EXEC;
          end
        end

        ST_EXEC: begin
          case (cmd_r)
            CMD_UP:       if (pt_y != PT_ONE) pt_y <= pt_y - PT_ONE;
            CMD_DOWN:     if (pt_y != PT_MAX) pt_y <= pt_y + PT_ONE;
            CMD_LEFT:     if (pt_x != PT_ONE) pt_x <= pt_x - PT_ONE;
            CMD_RIGHT:    if (pt_x != PT_MAX) pt_x <= pt_x + PT_ONE;
            CMD_RECENTER: begin
              pt_x <= PT_MID;
              pt_y <= PT_MID;
            end
            default: ;
          endcase
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        ST_WRITE: begin
          if (!wr_last) begin
            IRAM_valid <= 1'b1;
            IRAM_A     <= wr_idx;
            IRAM_D     <= pix[wr_idx];
            if (wr_idx == A_LAST) begin
              wr_last <= 1'b1;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end else begin
            IRAM_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end
        end

        ST_DONE: begin
          done <= 1'b1;
        end

        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
module tb_lcd_ctrl_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       reset = 1'b1;
  logic [3:0] cmd = '0;
  logic       cmd_valid = 1'b0;
  logic [7:0] irom_q = '0;
  logic       irom_rd;
  logic [5:0] irom_a;
  logic       iram_valid;
  logic [7:0] iram_d;
  logic [5:0] iram_a;
  logic       busy, done;

  // IMG_LOG2=2, DATA_W=10 instance
  logic       r2 = 1'b1;
  logic [3:0] cmd2 = '0;
  logic       cv2 = 1'b0;
  logic [9:0] q2 = '0;
  logic       rd2;
  logic [3:0] a2;
  logic       v2;
  logic [9:0] d2;
  logic [3:0] ia2;
  logic       busy2, done2;

  lcd_ctrl_param dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_Q(irom_q), .IROM_rd(irom_rd), .IROM_A(irom_a),
    .IRAM_valid(iram_valid), .IRAM_D(iram_d), .IRAM_A(iram_a),
    .busy(busy), .done(done)
  );

  lcd_ctrl_param #(.IMG_LOG2(2), .DATA_W(10)) dut2 (
    .clk(clk), .reset(r2), .cmd(cmd2), .cmd_valid(cv2),
    .IROM_Q(q2), .IROM_rd(rd2), .IROM_A(a2),
    .IRAM_valid(v2), .IRAM_D(d2), .IRAM_A(ia2),
    .busy(busy2), .done(done2)
  );

  logic [7:0] rom1 [64];
  logic [9:0] rom2 [16];
  int         exp1 [64];

  always @(posedge clk) if (irom_rd) irom_q <= rom1[irom_a];
  always @(posedge clk) if (rd2) q2 <= rom2[a2];

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] sb1 [$];
  logic [31:0] sb2 [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, want);
  endtask

  // scoreboard monitors: compare every IRAM write against the queued expectation
  always @(negedge clk) begin
    logic [31:0] e;
    if (iram_valid === 1'b1) begin
      n_checks++;
      if (sb1.size() == 0) begin
        $display("FAIL iram_extra: got addr %0d data %0d expected no write", iram_a, iram_d);
      end else begin
        e = sb1.pop_front();
        if (e === {16'(iram_a), 16'(iram_d)}) n_pass++;
        else $display("FAIL iram_write: got addr %0d data %0d expected addr %0d data %0d",
                      iram_a, iram_d, e[31:16], e[15:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (v2 === 1'b1) begin
      n_checks++;
      if (sb2.size() == 0) begin
        $display("FAIL iram2_extra: got addr %0d data %0d expected no write", ia2, d2);
      end else begin
        e = sb2.pop_front();
        if (e === {16'(ia2), 16'(d2)}) n_pass++;
        else $display("FAIL iram2_write: got addr %0d data %0d expected addr %0d data %0d",
                      ia2, d2, e[31:16], e[15:0]);
      end
    end
  end

  task automatic start1(input bit hold_cmd);
    int errs, lat;
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctl", {irom_rd, iram_valid, busy, done}, 4'b0010);
    chk("rst_data", {irom_a, iram_a, iram_d}, 0);
    sb1.delete();
    for (int k = 0; k < 64; k++) exp1[k] = k;
    if (hold_cmd) begin
      cmd = 4'd5;
      cmd_valid = 1'b1;
    end
    reset = 1'b0;
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (!(irom_rd === 1'b1 && irom_a === 6'(k))) errs++;
    end
    chk("load_seq_errs", errs, 0);
    lat = 0;
    while (busy !== 1'b0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
    chk("busy_fall_lat", lat, 2);
    chk("rd_off", irom_rd, 0);
  endtask

  task automatic cmd1(input logic [3:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_exec", busy, 1);
    @(negedge clk);
    chk("busy_back", busy, 0);
  endtask

  task automatic set4(input int a0, input int v0, input int a1, input int v1,
                      input int a2_, input int v2_, input int a3, input int v3);
    exp1[a0] = v0; exp1[a1] = v1; exp1[a2_] = v2_; exp1[a3] = v3;
  endtask

  task automatic push_all1();
    for (int k = 0; k < 64; k++) sb1.push_back({16'(k), 16'(exp1[k])});
  endtask

  task automatic writeout1();
    int n;
    push_all1();
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("sb1_empty", sb1.size(), 0);
  endtask

  logic [3:0] tc_cmd [8] = '{4'd5, 4'd6, 4'd7, 4'd12, 4'd8, 4'd9, 4'd10, 4'd11};
  // window TL, TR, BL, BR at addresses 27, 28, 35, 36 (ROM[k]=k, point (4,4))
  int tc_exp [8][4] = '{'{36, 36, 36, 36}, '{27, 27, 27, 27}, '{31, 31, 31, 31},
                        '{228, 227, 220, 219}, '{28, 36, 27, 35}, '{35, 27, 36, 28},
                        '{35, 36, 27, 28}, '{28, 27, 36, 35}};

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int errs, lat, n;
    for (int k = 0; k < 64; k++) rom1[k] = 8'(k);
    for (int k = 0; k < 16; k++) rom2[k] = 10'(k);
    rom2[5] = 10'd1023; rom2[6] = 10'd1023; rom2[9] = 10'd1023; rom2[10] = 10'd1020;

    // identity load with cmd_valid held through LOAD, write-out, DONE ignores commands
    start1(1'b1);
    writeout1();
    cmd = 4'd5;
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    chk("done_hold", {done, busy, iram_valid}, 3'b100);

    // single window operations at point (4,4)
    for (int i = 0; i < 8; i++) begin
      start1(1'b0);
      cmd1(tc_cmd[i]);
      set4(27, tc_exp[i][0], 28, tc_exp[i][1], 35, tc_exp[i][2], 36, tc_exp[i][3]);
      writeout1();
    end

    // top / right boundaries, then recenter
    start1(1'b0);
    repeat (5) cmd1(4'd1);
    cmd1(4'd5);
    set4(3, 12, 4, 12, 11, 12, 12, 12);
    repeat (5) cmd1(4'd4);
    cmd1(4'd5);
    set4(6, 15, 7, 15, 14, 15, 15, 15);
    cmd1(4'd13);
    cmd1(4'd5);
    set4(27, 36, 28, 36, 35, 36, 36, 36);
    writeout1();

    // bottom / left boundaries
    start1(1'b0);
    repeat (5) cmd1(4'd2);
    repeat (5) cmd1(4'd3);
    cmd1(4'd6);
    set4(48, 48, 49, 48, 56, 48, 57, 48);
    writeout1();

    // reserved codes leave the image alone
    start1(1'b0);
    cmd1(4'd14);
    cmd1(4'd15);
    writeout1();

    // reset in the middle of a write-out
    start1(1'b0);
    cmd1(4'd12);
    set4(27, 228, 28, 227, 35, 220, 36, 219);
    push_all1();
    cmd = 4'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    chk("partial_writes", 64 - sb1.size(), 11);
    start1(1'b0);
    writeout1();

    // small image instance: 4x4, 10-bit pixels, AVG at (2,2)
    r2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst2_ctl", {rd2, v2, busy2, done2}, 4'b0010);
    r2 = 1'b0;
    errs = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (!(rd2 === 1'b1 && a2 === 4'(k))) errs++;
    end
    chk("load2_seq_errs", errs, 0);
    lat = 0;
    while (busy2 !== 1'b0 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("busy2_fall_lat", lat, 2);
    cmd2 = 4'd7;
    cv2 = 1'b1;
    @(negedge clk);
    cv2 = 1'b0;
    chk("busy2_exec", busy2, 1);
    @(negedge clk);
    chk("busy2_back", busy2, 0);
    for (int k = 0; k < 16; k++) begin
      if (k == 5 || k == 6 || k == 9 || k == 10) sb2.push_back({16'(k), 16'd1022});
      else sb2.push_back({16'(k), 16'(k)});
    end
    cmd2 = 4'd0;
    cv2 = 1'b1;
    @(negedge clk);
    cv2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done2", done2, 1);
    chk("done2_busy", busy2, 0);
    chk("sb2_empty", sb2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
- Parametrised LCD image controller for an N x N image, N = 2**IMG_LOG2.
- Loads the full image from IROM into an internal pixel buffer.
- Executes host commands on a 2x2 window anchored at a movable operation point, then streams the buffer to IRAM and flags done.
- Sits between the host command interface and the IROM/IRAM macros. Adds two commands and a "recenter" operation over the fixed-8x8 generation.

Parameters:
- IMG_LOG2, 3, log2 of image side N (N = 2**IMG_LOG2, legal 2..5).
- DATA_W, 8, pixel width in bits.
- ADDR_W, 2*IMG_LOG2, derived pixel address width (row-major: {y,x}).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd  in  4  command code, sampled when cmd_valid && !busy.
- cmd_valid  in  1  command strobe.
- IROM_Q  in  DATA_W  ROM read data, valid one cycle after IROM_rd/IROM_A.
- IROM_rd  out  1  ROM read enable.
- IROM_A  out  ADDR_W  ROM address.
- IRAM_valid  out  1  RAM write enable.
- IRAM_D  out  DATA_W  RAM write data.
- IRAM_A  out  ADDR_W  RAM write address.
- busy  out  1  high when no command can be accepted.
- done  out  1  high once the write-out is complete.

Behaviour:
- Reset values: IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_D=0, IRAM_A=0, busy=1, done=0. Operation point (x,y)=(N/2,N/2). Buffer contents are don't-care.
- Reset asserted in any state aborts everything. On release the block restarts from LOAD.
- States: LOAD -> IDLE -> EXEC -> IDLE ... IDLE --cmd 0--> WRITE -> DONE.
- LOAD:
  - IROM_rd=1 with IROM_A=0..N*N-1 on consecutive cycles, first cycle after reset release.
  - IROM_Q for address k is stored into buffer[k] on the edge after k is presented.
  - After the last sample is captured, busy falls (busy=0 the cycle after the last ROM data edge) and the state goes to IDLE; IROM_rd=0.
- IDLE: busy=0. cmd_valid with busy=0 accepts cmd; busy=1 the next cycle. cmd_valid while busy=1 is ignored (no queueing).
- EXEC: exactly one cycle, buffer/point update, then busy=0.
- Window definitions: TL=(y-1,x-1), TR=(y-1,x), BL=(y,x-1), BR=(y,x). Point range x,y in 1..N-1.
- Commands (cmd codes):
  - 0: write-out.
  - 1: up, y-- unless y=1.
  - 2: down, y++ unless y=N-1.
  - 3: left, x-- unless x=1.
  - 4: right, x++ unless x=N-1.
  - Shifts at a boundary are a no-op but still take the EXEC cycle.
  - 5 MAX: all four pixels <= max of the window.
  - 6 MIN: all four pixels <= min of the window.
  - 7 AVG: all four pixels <= floor(sum/4). sum is DATA_W+2 bits, no overflow.
  - 8 CCW: TL<=TR, TR<=BR, BR<=BL, BL<=TL.
  - 9 CW: TL<=BL, BL<=BR, BR<=TR, TR<=TL.
  - 10 mirror-X (vertical flip): TL<->BL, TR<->BR.
  - 11 mirror-Y (horizontal flip): TL<->TR, BL<->BR.
  - 12 INVERT: each window pixel <= bitwise NOT.
  - 13 RECENTER: (x,y) <= (N/2,N/2), buffer untouched.
  - 14, 15: reserved no-op, one busy cycle.
- WRITE:
  - IRAM_valid=1 for exactly N*N consecutive cycles.
  - IRAM_A=0..N*N-1 in order; IRAM_D=buffer[IRAM_A] in the same cycle.
  - busy stays 1.
- DONE:
  - Entered the cycle after the last write; IRAM_valid=0, busy=0, done=1, held until reset.
  - cmd_valid in DONE is ignored.
- All arithmetic is unsigned.
- A command and the exit from LOAD never coincide, because busy=1 throughout LOAD.

Decomposition:
- Shared package lcd_ctrl_pkg:
  - cmd code localparams (CMD_WRITE..CMD_RECENTER).
  - FSM state enum (ST_LOAD, ST_IDLE, ST_EXEC, ST_WRITE, ST_DONE).
- One sub-module, lcd_win_alu: combinational, parameter DATA_W.
  - Inputs: TL/TR/BL/BR and cmd. Outputs: four new pixel values plus a write-enable.
  - The top level keeps the FSM, the point registers, the buffer and the ROM/RAM sequencing.

Test Plan:
- Default params, ROM[k]=k: after reset release, IROM_A steps 0..63 with IROM_rd=1, busy falls; an immediate cmd 0 writes IRAM_A=k, D=k for all 64 cycles, then done=1, busy=0.
- Point (4,4), window TL..BR = 27,28,35,36:
  - cmd 5 -> all 36; cmd 6 -> all 27; cmd 7 -> all 31.
  - cmd 12 -> 228,227,220,219.
- Rotations/mirrors on window 27,28,35,36:
  - cmd 8 -> TL=28, TR=36, BL=27, BR=35.
  - cmd 9 -> TL=35, TR=27, BL=36, BR=28.
  - cmd 10 -> 35,36,27,28.
  - cmd 11 -> 28,27,36,35.
- Boundaries:
  - cmd 1 issued five times from y=4 -> y stops at 1.
  - cmd 4 issued five times -> x stops at 7.
  - cmd 13 -> point (4,4).
  - Verify via MAX at each boundary and the write-out contents.
- Handshake/robustness:
  - cmd_valid held high during LOAD -> ignored.
  - cmd 14 -> busy for 1 cycle, image unchanged.
  - reset pulse mid-WRITE -> outputs return to reset values and the reload starts at IROM_A=0.
- IMG_LOG2=2, DATA_W=10:
  - 16-pixel load and write-out.
  - Point (2,2); AVG of 1023,1023,1023,1020 -> 1022.
